regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (regWrite / addrDestination / writeData) among NREQ writeback requesters: ALU, load unit and syscall/debug path.
- Round-robin arbitration, one grant per cycle, with a valid/ready handshake per requester.
- Holds a 32-entry pending-write scoreboard: decode reserves a destination, the matching write clears it, and decode uses busy flags to stall on hazards.
- Sits between the writeback sources and the register file.

Parameters:
- NREQ, 3, number of write requesters (2..4); index 0 = ALU, 1 = MEM, 2 = SYS.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  write request per requester
- req_ready  out  NREQ  grant; handshake completes when valid and ready are both high
- req_addr  in  NREQ*AW  destination per requester; requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data per requester; requester i at bits [i*DW +: DW]
- rsv_valid  in  1  decode reserves a destination
- rsv_addr  in  AW  register being reserved
- rsv_ready  out  1  reservation accepted
- chk_addr_a  in  AW  hazard-check address (rs)
- chk_addr_b  in  AW  hazard-check address (rt)
- busy_a  out  1  pending[chk_addr_a]
- busy_b  out  1  pending[chk_addr_b]
- flush  in  1  synchronous pipeline flush
- pending_mask  out  32  scoreboard state
- wr_en  out  1  to register file regWrite
- wr_addr  out  AW  to register file addrDestination
- wr_data  out  DW  to register file writeData

Behaviour:
- Reset (asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0, pending_mask=0.
  - rr_ptr=NREQ-1, so requester 0 has top priority first.
- Arbitration (combinational from registered state):
  - Search order starts at rr_ptr+1 modulo NREQ; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - All other ready lines are 0. Ready never asserts without valid.
  - On a grant, rr_ptr takes the granted index at the clock edge. Without a grant, rr_ptr holds.
- Output latency:
  - The granted addr/data are registered onto wr_addr/wr_data, with wr_en=1, on the cycle after the handshake. Latency is exactly 1.
  - Cycles without a grant drive wr_en=0; wr_addr/wr_data hold their last values.
- Register 0:
  - A grant to addr 0 completes the handshake but drives wr_en=0.
  - Reservations of addr 0 are accepted with no effect; pending[0] stays 0.
- Scoreboard:
  - rsv_ready = !pending[rsv_addr] && !flush.
  - Reservation handshake sets pending[rsv_addr].
  - A write grant to a register clears its pending bit. A write to a non-pending register is legal and leaves the mask unchanged.
  - Same-cycle grant to X and reservation of X, with X not pending: bit ends set (set wins).
  - A reservation to an already pending register stalls (WAW blocked).
- busy_a/busy_b: combinational reads of pending_mask. busy for addr 0 is always 0.
- Flush (one cycle):
  - All req_ready=0 and rsv_ready=0.
  - pending_mask cleared at the edge; wr_en=0 next cycle; rr_ptr held.
  - Requests left pending across a flush are re-arbitrated afterward.
- Reset mid-operation: all state is cleared immediately; any in-flight registered write is discarded (wr_en=0).
- Requester inputs must stay stable while valid is high and ready is low.

Optional Feature:
- Macro: REGWR_ARB_STATS_EN.
- When defined, two outputs are added:
  - grant_cnt (NREQ*16): per-requester successful grants, 16-bit each, saturating at 16'hFFFF.
  - stall_cnt (16): cycles with rsv_valid=1 and rsv_ready=0, saturating.
- Both counters reset to 0 by rst only; flush does not clear them.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- After reset, req_valid=3'b111 held 6 cycles, addrs 8/9/10 → grants ordered 0,1,2,0,1,2; wr_en high from cycle 2 with wr_addr 8,9,10,8,9,10.
- Req1 alone, addr=5, data=32'hDEADBEEF → req_ready[1]=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
- Reserve r9, then chk_addr_a=9 → busy_a=1. A second reserve of r9 → rsv_ready=0. After the MEM write to r9 → pending[9]=0, busy_a=0.
- ALU write to addr 0 with data 32'h1234 → handshake completes, wr_en stays 0; reserve r0 → rsv_ready=1, pending_mask stays 0.
- Reserve r3 and r7, then pulse flush with req_valid=3'b001 → req_ready=0 during flush, pending_mask=0 next cycle; request granted the cycle after.
- Assert rst while wr_en=1 → wr_en, pending_mask and rr_ptr clear without a clock edge. With REGWR_ARB_STATS_EN, grant_cnt reads 0 and 16'hFFFF saturation holds after 70000 grants.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port among NREQ writeback
// sources, with a 32-entry pending-write scoreboard. Optional counters: REGWR_ARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  input  logic [AW-1:0]        chk_addr_a,
  input  logic [AW-1:0]        chk_addr_b,
  output logic                 busy_a,
  output logic                 busy_b,
  input  logic                 flush,
  output logic [31:0]          pending_mask,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data
`ifdef REGWR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW:0]     start;
  logic [NREQ-1:0] req_rot;
  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic [31:0]     pending_q;
  logic [31:0]     pending_nxt;

  // Rotate the request vector so bit 0 is the requester just after the last winner.
  assign start   = {1'b0, rr_ptr} + 1'b1;
  assign req_rot = NREQ'({req_valid, req_valid} >> start);

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    int sum;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    sum       = 0;
    if (!flush) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_vld && req_rot[k]) begin
          gnt_vld = 1'b1;
          sum     = int'(rr_ptr) + 1 + k;
          if (sum >= NREQ) sum = sum - NREQ;
          gnt_idx = PW'(sum);
        end
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_addr = req_addr[int'(gnt_idx)*AW +: AW];
  assign gnt_data = req_data[int'(gnt_idx)*DW +: DW];

  assign rsv_ready    = !pending_q[rsv_addr] && !flush;
  assign busy_a       = (chk_addr_a != '0) && pending_q[chk_addr_a];
  assign busy_b       = (chk_addr_b != '0) && pending_q[chk_addr_b];
  assign pending_mask = pending_q;

  // Clear for the completing write is applied before the set, so a same-cycle reserve wins.
  always_comb begin
    pending_nxt = pending_q;
    if (flush) begin
      pending_nxt = '0;
    end else begin
      if (gnt_vld)                pending_nxt[gnt_addr] = 1'b0;
      if (rsv_valid && rsv_ready) pending_nxt[rsv_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= PW'(NREQ - 1);
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pending_q <= '0;
    end else begin
      wr_en     <= gnt_vld && (gnt_addr != '0);
      pending_q <= pending_nxt;
      if (gnt_vld) begin
        rr_ptr  <= gnt_idx;
        wr_addr <= gnt_addr;
        wr_data <= gnt_data;
      end
    end
  end

`ifdef REGWR_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (rsv_valid && !rsv_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural model. Build with REGWR_ARB_STATS_EN for counters.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic [AW-1:0]       chk_addr_a;
  logic [AW-1:0]       chk_addr_b;
  logic                busy_a;
  logic                busy_b;
  logic                flush;
  logic [31:0]         pending_mask;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
`ifdef REGWR_ARB_STATS_EN
  logic [NREQ*16-1:0]  grant_cnt;
  logic [15:0]         stall_cnt;
`endif

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .flush(flush), .pending_mask(pending_mask),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef REGWR_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: set of pending registers, index of the last winner, latched write.
  logic [31:0]     m_pend;
  int              m_last;
  logic            m_wr_en;
  logic [AW-1:0]   m_wr_addr;
  logic [DW-1:0]   m_wr_data;
  int              m_gcnt [NREQ];
  int              m_stall;

  logic [NREQ-1:0] smp_ready;
  logic            smp_rsv;
  logic            smp_busy_a;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] exp_ready;
    logic            exp_wr_en;
    logic [AW-1:0]   exp_wr_addr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend    = '0;
    m_last    = NREQ - 1;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_stall   = 0;
    for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // Winner is the first valid requester after the previous winner, wrapping around.
  function automatic int exp_grant();
    if (flush) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    int              g;
    logic [NREQ-1:0] er;
    logic            ers;
    #3;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ers = !m_pend[rsv_addr] && !flush;
    smp_ready  = req_ready;
    smp_rsv    = rsv_ready;
    smp_busy_a = busy_a;
    check({tag, " req_ready"}, 64'(req_ready), 64'(er));
    check({tag, " rsv_ready"}, 64'(rsv_ready), 64'(ers));
    check({tag, " busy_a"},    64'(busy_a),    64'(m_pend[chk_addr_a]));
    check({tag, " busy_b"},    64'(busy_b),    64'(m_pend[chk_addr_b]));
    @(posedge clk);
    if (g >= 0) begin
      if (m_gcnt[g] < 65535) m_gcnt[g]++;
    end
    if (rsv_valid && !ers && m_stall < 65535) m_stall++;
    m_wr_en = (g >= 0) && (addr_of(g) != 0);
    if (g >= 0) begin
      m_wr_addr = addr_of(g);
      m_wr_data = data_of(g);
      m_last    = g;
    end
    if (flush) begin
      m_pend = '0;
    end else begin
      if (g >= 0) m_pend[addr_of(g)] = 1'b0;
      if (rsv_valid && ers && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
    #1;
    check({tag, " wr_en"}, 64'(wr_en), 64'(m_wr_en));
    if (m_wr_en) begin
      check({tag, " wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
      check({tag, " wr_data"}, 64'(wr_data), 64'(m_wr_data));
    end
    check({tag, " pending_mask"}, 64'(pending_mask), 64'(m_pend));
`ifdef REGWR_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      check({tag, " grant_cnt"}, 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
    check({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  initial begin
    vec_t rr_tab [6];
    rr_tab[0] = '{valid: 3'b111, exp_ready: 3'b001, exp_wr_en: 1'b1, exp_wr_addr: 5'd8};
    rr_tab[1] = '{valid: 3'b111, exp_ready: 3'b010, exp_wr_en: 1'b1, exp_wr_addr: 5'd9};
    rr_tab[2] = '{valid: 3'b111, exp_ready: 3'b100, exp_wr_en: 1'b1, exp_wr_addr: 5'd10};
    rr_tab[3] = '{valid: 3'b111, exp_ready: 3'b001, exp_wr_en: 1'b1, exp_wr_addr: 5'd8};
    rr_tab[4] = '{valid: 3'b111, exp_ready: 3'b010, exp_wr_en: 1'b1, exp_wr_addr: 5'd9};
    rr_tab[5] = '{valid: 3'b111, exp_ready: 3'b100, exp_wr_en: 1'b1, exp_wr_addr: 5'd10};

    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; chk_addr_a = '0; chk_addr_b = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset wr_en",        64'(wr_en),        64'(0));
    check("reset wr_addr",      64'(wr_addr),      64'(0));
    check("reset wr_data",      64'(wr_data),      64'(0));
    check("reset pending_mask", 64'(pending_mask), 64'(0));

    // Round-robin rotation with all three requesters active.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8 + i), DW'(32'h100 + i));
    for (int v = 0; v < 6; v++) begin
      req_valid = rr_tab[v].valid;
      cycle("rr");
      check("rr table ready",   64'(smp_ready), 64'(rr_tab[v].exp_ready));
      check("rr table wr_en",   64'(wr_en),     64'(rr_tab[v].exp_wr_en));
      check("rr table wr_addr", 64'(wr_addr),   64'(rr_tab[v].exp_wr_addr));
    end

    // Single MEM requester, one-cycle latency.
    req_valid = '0;
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle("mem");
    check("mem ready",   64'(smp_ready), 64'(3'b010));
    check("mem wr_addr", 64'(wr_addr),   64'(5));
    check("mem wr_data", 64'(wr_data),   64'(32'hDEADBEEF));
    req_valid = '0;
    cycle("idle");
    check("idle wr_en", 64'(wr_en), 64'(0));

    // Scoreboard: reserve, WAW stall, clear on write.
    rsv_valid = 1'b1; rsv_addr = 5'd9; chk_addr_a = 5'd9;
    cycle("rsv9");
    cycle("rsv9 again");
    check("waw rsv_ready", 64'(smp_rsv),    64'(0));
    check("busy_a r9",     64'(smp_busy_a), 64'(1));
    rsv_valid = 1'b0;
    set_req(1, 1'b1, 5'd9, 32'h0000_0009);
    cycle("wr9");
    req_valid = '0;
    check("pending r9 cleared", 64'(pending_mask[9]), 64'(0));
    check("busy_a r9 cleared",  64'(busy_a),          64'(0));

    // Register 0: handshake completes without a write; reserve has no effect.
    set_req(0, 1'b1, 5'd0, 32'h1234);
    cycle("r0 write");
    check("r0 ready", 64'(smp_ready), 64'(3'b001));
    check("r0 wr_en", 64'(wr_en),     64'(0));
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    cycle("r0 rsv");
    check("r0 rsv_ready", 64'(smp_rsv),      64'(1));
    check("r0 pending",   64'(pending_mask), 64'(0));

    // Flush drops reservations and blocks grants for one cycle.
    rsv_addr = 5'd3; cycle("rsv3");
    rsv_addr = 5'd7; cycle("rsv7");
    rsv_addr = 5'd12;
    set_req(0, 1'b1, 5'd4, 32'hCAFE_0004);
    flush = 1'b1;
    cycle("flush");
    check("flush ready",     64'(smp_ready),    64'(0));
    check("flush rsv_ready", 64'(smp_rsv),      64'(0));
    check("flush pending",   64'(pending_mask), 64'(0));
    check("flush wr_en",     64'(wr_en),        64'(0));
    flush = 1'b0; rsv_valid = 1'b0;
    cycle("post flush");
    check("post flush ready",   64'(smp_ready), 64'(3'b001));
    check("post flush wr_addr", 64'(wr_addr),   64'(4));
    req_valid = '0;

    // Randomized traffic; a requester not granted keeps its inputs stable.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !smp_ready[i]))
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      end
      rsv_valid  = 1'($urandom_range(0, 1));
      rsv_addr   = AW'($urandom_range(0, 15));
      chk_addr_a = AW'($urandom_range(0, 15));
      chk_addr_b = AW'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    flush = 1'b0; rsv_valid = 1'b0; req_valid = '0;

    // Asynchronous reset while a write is in flight.
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    set_req(1, 1'b1, 5'd6, 32'h6666_6666);
    cycle("pre rst");
    rsv_valid = 1'b0;
    req_valid = 3'b111;
    #2 rst = 1'b1;
    #1;
    check("async rst wr_en",   64'(wr_en),        64'(0));
    check("async rst wr_addr", 64'(wr_addr),      64'(0));
    check("async rst pending", 64'(pending_mask), 64'(0));
    check("async rst rr_ptr",  64'(req_ready),    64'(3'b001));
`ifdef REGWR_ARB_STATS_EN
    check("async rst grant_cnt", 64'(grant_cnt), 64'(0));
    check("async rst stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    req_valid = '0;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    set_req(2, 1'b1, 5'd11, 32'hB0B0_000B);
    cycle("after rst");
    req_valid = '0;

`ifdef REGWR_ARB_STATS_EN
    // Saturation of the ALU grant counter.
    set_req(0, 1'b1, 5'd1, 32'h1);
    repeat (70000) @(posedge clk);
    #1;
    check("grant_cnt sat", 64'(grant_cnt[15:0]),  64'(16'hFFFF));
    check("grant_cnt sys", 64'(grant_cnt[47:32]), 64'(1));
    req_valid = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
